// File: rtl/stim_gen_if.sv
// Control and operand bus between the arithmetic-bench controller and the stim_gen operand source.
interface stim_gen_if #(
  parameter int unsigned WIDTH = 32
);
  logic              i_start;
  logic              i_stop;
  logic [1:0]        i_mode;
  logic [31:0]       i_num_vec;
  logic              i_event;
  logic [WIDTH-1:0]  o_dut_ia;
  logic [WIDTH-1:0]  o_dut_ib;
  logic              o_valid;
  logic              o_busy;
  logic              o_done;
  logic              o_pass;
  logic [31:0]       o_vec_cnt;
  logic [15:0]       o_err_cnt;

  // Controller side: issues campaigns, observes operands and status.
  modport master (
    output i_start, i_stop, i_mode, i_num_vec, i_event,
    input  o_dut_ia, o_dut_ib, o_valid, o_busy, o_done, o_pass, o_vec_cnt, o_err_cnt
  );

  // Generator side.
  modport slave (
    input  i_start, i_stop, i_mode, i_num_vec, i_event,
    output o_dut_ia, o_dut_ib, o_valid, o_busy, o_done, o_pass, o_vec_cnt, o_err_cnt
  );
endinterface

// File: rtl/stim_gen.sv
// Operand stimulus source: random (Galois LFSR), sweep or corner-table vector campaigns with
// mismatch-event counting over the run plus a fixed drain window.
module stim_gen #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] SEED_A       = 32'h1,
  parameter logic [31:0] SEED_B       = 32'h2,
  parameter logic [31:0] POLY         = 32'hA300_0000,
  parameter int unsigned DRAIN_CYCLES = 8
) (
  input logic       clk,
  input logic       reset,
  stim_gen_if.slave bus
);

  localparam logic [WIDTH-1:0] Poly  = WIDTH'(POLY);
  localparam logic [WIDTH-1:0] SeedA = (WIDTH'(SEED_A) == '0) ? WIDTH'(1) : WIDTH'(SEED_A);
  localparam logic [WIDTH-1:0] SeedB = (WIDTH'(SEED_B) == '0) ? WIDTH'(1) : WIDTH'(SEED_B);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [31:0]      num_q, num_d;
  logic [31:0]      vec_cnt_q, vec_cnt_d;
  logic [15:0]      err_q, err_d;
  logic [31:0]      drain_q, drain_d;
  logic [3:0]       idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] a_nxt, b_nxt;
  logic [3:0]       idx_nxt;
  logic             start_ok, last_vec, busy;

  function automatic logic [WIDTH-1:0] corner(input logic [1:0] i);
    logic [WIDTH-1:0] v;
    unique case (i)
      2'd0:    v = '0;
      2'd1:    v = WIDTH'(1);
      2'd2:    v = '1;
      default: v = {1'b1, {(WIDTH-1){1'b0}}};
    endcase
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] lfsr(input logic [WIDTH-1:0] v);
    return {1'b0, v[WIDTH-1:1]} ^ (v[0] ? Poly : '0);
  endfunction

  assign start_ok = ((state_q == StIdle) || (state_q == StDone)) && bus.i_start;
  assign last_vec = (num_q != '0) && ((vec_cnt_q + 32'd1) == num_q);
  assign busy     = (state_q == StRun) || (state_q == StDrain);

  // Vector following the one currently presented, per latched mode.
  always_comb begin
    a_nxt   = a_q;
    b_nxt   = b_q;
    idx_nxt = idx_q + 4'd1;
    unique case (mode_q)
      2'd1: begin
        a_nxt = a_q + WIDTH'(1);
        if (&a_q) b_nxt = b_q + WIDTH'(1);
      end
      2'd2: begin
        a_nxt = corner(idx_nxt[1:0]);
        b_nxt = corner(idx_nxt[3:2]);
      end
      default: begin
        a_nxt = lfsr(a_q);
        b_nxt = lfsr(b_q);
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    num_d     = num_q;
    vec_cnt_d = vec_cnt_q;
    err_d     = err_q;
    drain_d   = '0;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;

    unique case (state_q)
      StIdle, StDone: if (bus.i_start) state_d = StRun;
      StRun:          if (bus.i_stop || last_vec) state_d = StDrain;
      StDrain: begin
        if (drain_q == DRAIN_CYCLES - 1) state_d = StDone;
        else                             drain_d = drain_q + 32'd1;
      end
      default:        state_d = StIdle;
    endcase

    if (start_ok) begin
      mode_d    = bus.i_mode;
      num_d     = bus.i_num_vec;
      vec_cnt_d = '0;
      err_d     = '0;
      idx_d     = '0;
      a_d       = (bus.i_mode == 2'd1 || bus.i_mode == 2'd2) ? '0 : SeedA;
      b_d       = (bus.i_mode == 2'd1 || bus.i_mode == 2'd2) ? '0 : SeedB;
    end

    if (state_q == StRun) begin
      vec_cnt_d = vec_cnt_q + 32'd1;
      // Only advance while staying in RUN so the last issued vector is held afterwards.
      if (state_d == StRun) begin
        a_d   = a_nxt;
        b_d   = b_nxt;
        idx_d = idx_nxt;
      end
    end

    if (busy && bus.i_event && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      mode_q    <= '0;
      num_q     <= '0;
      vec_cnt_q <= '0;
      err_q     <= '0;
      drain_q   <= '0;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      num_q     <= num_d;
      vec_cnt_q <= vec_cnt_d;
      err_q     <= err_d;
      drain_q   <= drain_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

  assign bus.o_dut_ia  = a_q;
  assign bus.o_dut_ib  = b_q;
  assign bus.o_valid   = (state_q == StRun);
  assign bus.o_busy    = busy;
  assign bus.o_done    = (state_q == StDone);
  assign bus.o_pass    = (state_q == StDone) && (err_q == '0);
  assign bus.o_vec_cnt = vec_cnt_q;
  assign bus.o_err_cnt = err_q;

endmodule

// File: tb/tb_stim_gen.sv
// Self-checking bench for stim_gen: campaign table, hand-written corner sequences and random
// campaigns compared against a reference model built from the operand-generation rules.
module tb_stim_gen;

  localparam int unsigned W     = 32;
  localparam logic [31:0] SEEDA = 32'h1;
  localparam logic [31:0] SEEDB = 32'h2;
  localparam logic [31:0] POLYM = 32'hA300_0000;
  localparam int          DRAIN = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ra, rb;  // reference random operand state

  always #5 clk = ~clk;

  stim_gen_if #(.WIDTH(W)) bus ();

  stim_gen #(
    .WIDTH       (W),
    .SEED_A      (SEEDA),
    .SEED_B      (SEEDB),
    .POLY        (POLYM),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] num;
    int          stop_at;   // 0 = never stop early, else stop on that vector (1-based)
    int          ev_mode;   // 0 none, 1 random events + stray starts, 2 events always high
    logic [31:0] exp_vec;
    logic        exp_pass;
  } camp_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? POLYM : 32'h0);
  endfunction

  function automatic logic [31:0] ctab(input longint i);
    logic [31:0] t[4];
    t[0] = 32'h0; t[1] = 32'h1; t[2] = 32'hFFFF_FFFF; t[3] = 32'h8000_0000;
    return t[i % 4];
  endfunction

  // Expected operands for vector k of a campaign.
  task automatic model_vec(input logic [1:0] mode, input longint k,
                           output logic [31:0] ea, output logic [31:0] eb);
    logic [63:0] kk;
    kk = 64'(k);
    case (mode)
      2'd1:    begin ea = kk[31:0]; eb = kk[63:32]; end
      2'd2:    begin ea = ctab(k % 4); eb = ctab((k / 4) % 4); end
      default: begin ea = ra; eb = rb; end
    endcase
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 64'(bus.o_valid), 64'd0);
    check({tag, "_busy"},  64'(bus.o_busy),  64'd0);
    check({tag, "_done"},  64'(bus.o_done),  64'd0);
    check({tag, "_pass"},  64'(bus.o_pass),  64'd0);
    check({tag, "_vec"},   64'(bus.o_vec_cnt), 64'd0);
    check({tag, "_err"},   64'(bus.o_err_cnt), 64'd0);
    check({tag, "_a"},     64'(bus.o_dut_ia), 64'd0);
    check({tag, "_b"},     64'(bus.o_dut_ib), 64'd0);
  endtask

  // Starts a campaign from IDLE/DONE and follows it to DONE, checking every cycle.
  task automatic campaign(input logic [1:0] mode, input logic [31:0] num, input int stop_at,
                          input int ev_mode, input bit with_stop,
                          output logic [31:0] vec_out, output logic pass_out);
    longint      k;
    int          drain_left, exp_err, budget;
    logic [31:0] ea, eb, la, lb;
    bit          ev, last, finished;
    k = 0; drain_left = -1; exp_err = 0; finished = 0; la = 0; lb = 0;
    vec_out = '1; pass_out = 1'bx;
    budget = ((num != 0) ? int'(num) : stop_at) + DRAIN + 4;
    ra = SEEDA; rb = SEEDB;
    bus.i_mode = mode; bus.i_num_vec = num; bus.i_start = 1'b1; bus.i_stop = with_stop;
    tick();
    bus.i_start = 1'b0; bus.i_stop = 1'b0;
    for (int c = 0; c < budget && !finished; c++) begin
      ev = (ev_mode == 2) || (ev_mode == 1 && $urandom_range(0, 3) == 0);
      if (drain_left < 0) begin
        model_vec(mode, k, ea, eb);
        check("run_valid", 64'(bus.o_valid), 64'd1);
        check("run_a", 64'(bus.o_dut_ia), 64'(ea));
        check("run_b", 64'(bus.o_dut_ib), 64'(eb));
        check("run_vec_cnt", 64'(bus.o_vec_cnt), 64'(k));
        la = ea; lb = eb;
        ra = lfsr_step(ra); rb = lfsr_step(rb);
        k++;
        last = (num != 0 && k == longint'(num)) || (stop_at != 0 && k == stop_at);
        bus.i_stop = (stop_at != 0 && k == stop_at);
        if (ev_mode == 1 && $urandom_range(0, 3) == 0) bus.i_start = 1'b1;
        if (last) drain_left = DRAIN;
        if (ev && exp_err < 65535) exp_err++;
      end else if (drain_left > 0) begin
        check("drain_busy", 64'(bus.o_busy), 64'd1);
        check("drain_valid", 64'(bus.o_valid), 64'd0);
        check("drain_hold_a", 64'(bus.o_dut_ia), 64'(la));
        check("drain_hold_b", 64'(bus.o_dut_ib), 64'(lb));
        if (ev_mode == 1 && $urandom_range(0, 3) == 0) bus.i_start = 1'b1;
        if (ev && exp_err < 65535) exp_err++;
        drain_left--;
      end else begin
        check("done_flag", 64'(bus.o_done), 64'd1);
        check("done_busy", 64'(bus.o_busy), 64'd0);
        check("done_vec_cnt", 64'(bus.o_vec_cnt), 64'(k));
        check("done_err_cnt", 64'(bus.o_err_cnt), 64'(exp_err));
        check("done_pass", 64'(bus.o_pass), 64'(exp_err == 0));
        check("done_hold_a", 64'(bus.o_dut_ia), 64'(la));
        vec_out = bus.o_vec_cnt;
        pass_out = bus.o_pass;
        finished = 1;
        ev = 1'b0;
      end
      bus.i_event = ev;
      if (!finished) begin
        tick();
        bus.i_start = 1'b0;
        bus.i_stop = 1'b0;
      end
    end
    bus.i_event = 1'b0;
    check("campaign_reached_done", 64'(finished), 64'd1);
    if (finished) begin
      // Events in DONE are ignored and the counts hold.
      bus.i_event = 1'b1;
      tick();
      bus.i_event = 1'b0;
      check("done_event_ignored", 64'(bus.o_err_cnt), 64'(exp_err));
      check("done_vec_hold", 64'(bus.o_vec_cnt), 64'(k));
    end
  endtask

  camp_t       tbl[6];
  logic [31:0] got_vec;
  logic        got_pass;
  logic [31:0] lit_a[3];
  logic [31:0] lit_b[3];

  initial begin
    tbl[0] = '{2'd2, 32'd16, 0,     0, 32'd16,    1'b1};
    tbl[1] = '{2'd0, 32'd3,  0,     0, 32'd3,     1'b1};
    tbl[2] = '{2'd1, 32'd0,  5,     0, 32'd5,     1'b1};
    tbl[3] = '{2'd3, 32'd20, 20,    0, 32'd20,    1'b1};  // stop on the terminal vector
    tbl[4] = '{2'd1, 32'd7,  0,     1, 32'd7,     1'b0};  // pass checked against model
    tbl[5] = '{2'd0, 32'd0,  70000, 2, 32'd70000, 1'b0};  // err counter saturation
    lit_a[0] = 32'h1; lit_a[1] = 32'hA300_0000; lit_a[2] = 32'h5180_0000;
    lit_b[0] = 32'h2; lit_b[1] = 32'h1;         lit_b[2] = 32'hA300_0000;

    reset = 1'b1;
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_mode = 2'd0;
    bus.i_num_vec = 32'd0; bus.i_event = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    bus.i_stop = 1'b1;  // stop in IDLE is ignored
    tick();
    bus.i_stop = 1'b0;
    check_idle_outputs("idle_stop");

    for (int i = 0; i < 6; i++) begin
      campaign(tbl[i].mode, tbl[i].num, tbl[i].stop_at, tbl[i].ev_mode, 1'b0, got_vec, got_pass);
      check($sformatf("tbl%0d_vec", i), 64'(got_vec), 64'(tbl[i].exp_vec));
      if (tbl[i].ev_mode != 1) check($sformatf("tbl%0d_pass", i), 64'(got_pass),
                                     64'(tbl[i].exp_pass));
    end

    // Literal random sequence from seeds 1/2.
    bus.i_mode = 2'd0; bus.i_num_vec = 32'd3; bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("lit_a%0d", k), 64'(bus.o_dut_ia), 64'(lit_a[k]));
      check($sformatf("lit_b%0d", k), 64'(bus.o_dut_ib), 64'(lit_b[k]));
      tick();
    end
    check("lit_left_run", 64'(bus.o_valid), 64'd0);
    repeat (DRAIN) tick();

    // Events: 3 in RUN, 2 in the last DRAIN cycles, 1 in DONE.
    bus.i_mode = 2'd2; bus.i_num_vec = 32'd4; bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    for (int c = 0; c < 4 + DRAIN; c++) begin
      bus.i_event = (c < 3) || (c == 4 + DRAIN - 2) || (c == 4 + DRAIN - 1);
      tick();
    end
    bus.i_event = 1'b1;
    check("ev_done", 64'(bus.o_done), 64'd1);
    tick();
    bus.i_event = 1'b0;
    check("ev_err_cnt", 64'(bus.o_err_cnt), 64'd5);
    check("ev_pass", 64'(bus.o_pass), 64'd0);

    // Reset mid-RUN at vector 7, with a stray start during RUN.
    ra = SEEDA; rb = SEEDB;
    bus.i_mode = 2'd0; bus.i_num_vec = 32'd0; bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check("mid_vec_cnt", 64'(bus.o_vec_cnt), 64'(k));
      check("mid_a", 64'(bus.o_dut_ia), 64'(ra));
      check("mid_b", 64'(bus.o_dut_ib), 64'(rb));
      ra = lfsr_step(ra); rb = lfsr_step(rb);
      bus.i_start = (k == 3);
      tick();
      bus.i_start = 1'b0;
    end
    check("mid_vec7", 64'(bus.o_vec_cnt), 64'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("mid_reset");
    // Restart with start and stop together in IDLE: stop ignored, sequence from seeds.
    campaign(2'd0, 32'd10, 0, 0, 1'b1, got_vec, got_pass);
    check("restart_vec", 64'(got_vec), 64'd10);

    // Random campaigns.
    for (int it = 0; it < 8; it++) begin
      logic [1:0]  m;
      logic [31:0] n, ev_exp;
      int          s;
      m = 2'($urandom_range(0, 3));
      n = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
      s = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 45));
      if (n == 0 && s == 0) s = 12;
      ev_exp = (n == 0) ? 32'(s) : ((s != 0 && 32'(s) < n) ? 32'(s) : n);
      campaign(m, n, s, 1, 1'b0, got_vec, got_pass);
      check($sformatf("rnd%0d_vec", it), 64'(got_vec), 64'(ev_exp));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
